// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: the default pointer width and
// the binary/Gray conversion helpers used by both pointer generators.
package fifo_pkg;

  // Default pointer width, including the wrap bit (depth = 2**(SIZE-1)).
  localparam int DEFAULT_SIZE = 4;

  // Widest pointer the helpers handle. Callers zero-extend into this width
  // and truncate the result. The conversions depend only on bits at or above
  // each position, so the zero padding does not change the low bits.
  localparam int MAX_PTR_W = 32;

  typedef logic [MAX_PTR_W-1:0] ptr_word_t;

  // Binary to reflected Gray code: each bit XORs with its upper neighbour.
  function automatic ptr_word_t bin_to_gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray to binary: each binary bit is the XOR of all Gray bits
  // at or above that position.
  function automatic ptr_word_t gray_to_bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = '0;
    for (int i = 0; i < MAX_PTR_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage : fifo_pkg

// File: rtl/pointer_sync.sv
// Two-flop synchronizer that brings a Gray-coded pointer from the other
// clock domain into the local domain. Because the source is Gray coded,
// at most one bit is in flight per change. A sample therefore resolves to
// either the old value or the new value, never to an unrelated value.
module pointer_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_q;

  // Two-stage capture; stage1 may go metastable, stage2 is the clean copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      // NOTE: non-blocking so stage2 takes stage1's old value; a blocking
      // assignment here would collapse the chain to a single flop.
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule : pointer_sync

// File: rtl/empty_gen.sv
// Read-side pointer and flag generator for the dual-clock FIFO.
// Holds the binary read pointer and its registered Gray copy. Synchronizes
// the write-side Gray pointer into the read domain. Produces registered
// empty, almost-empty and occupancy outputs. All outputs are computed from
// the post-read pointer, so empty rises on the same edge that consumes the
// last word.
module empty_gen
  import fifo_pkg::*;
#(
  parameter int SIZE               = DEFAULT_SIZE,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic            read_clock,
  input  logic            reset_n,
  input  logic            valid_read,
  input  logic [SIZE-1:0] write_gray_pointer,
  output logic [SIZE-1:0] read_count,
  output logic [SIZE-1:0] read_gray,
  output logic            empty_flag,
  output logic            almost_empty_flag,
  output logic [SIZE-1:0] read_level
);

  localparam logic [SIZE-1:0] AE_LEVEL = SIZE'(ALMOST_EMPTY_LEVEL);

  // Registered state.
  logic [SIZE-1:0] read_count_q;
  logic [SIZE-1:0] read_gray_q;
  logic            empty_q;
  logic            almost_empty_q;
  logic [SIZE-1:0] read_level_q;

  // Next-state values and synchronized write pointer.
  logic            rd_en;
  logic [SIZE-1:0] read_count_d;
  logic [SIZE-1:0] read_gray_d;
  logic            empty_d;
  logic            almost_empty_d;
  logic [SIZE-1:0] read_level_d;
  logic [SIZE-1:0] wgray_sync;
  logic [SIZE-1:0] wbin_sync;

  // Write-side Gray pointer crosses into the read domain through two flops.
  pointer_sync #(
    .WIDTH (SIZE)
  ) u_wptr_sync (
    .clk   (read_clock),
    .rst_n (reset_n),
    .d_i   (write_gray_pointer),
    .q_o   (wgray_sync)
  );

  // Next pointer, Gray copy, occupancy and flags from the post-read pointer.
  always_comb begin
    // NOTE: every variable gets a value on every pass through this block;
    // a path that leaves one unassigned would infer a latch.
    rd_en          = valid_read & ~empty_q;
    read_count_d   = read_count_q + {{(SIZE-1){1'b0}}, rd_en};
    read_gray_d    = SIZE'(bin_to_gray(MAX_PTR_W'(read_count_d)));
    wbin_sync      = SIZE'(gray_to_bin(MAX_PTR_W'(wgray_sync)));
    // Modulo-2**SIZE difference stays correct across pointer wrap.
    read_level_d   = wbin_sync - read_count_d;
    empty_d        = (read_gray_d == wgray_sync);
    almost_empty_d = (read_level_d <= AE_LEVEL);
  end

  // Pointer and flag registers. Reset leaves the FIFO empty.
  always_ff @(posedge read_clock or negedge reset_n) begin
    if (!reset_n) begin
      read_count_q   <= '0;
      read_gray_q    <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      read_level_q   <= '0;
    end else begin
      read_count_q   <= read_count_d;
      read_gray_q    <= read_gray_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      read_level_q   <= read_level_d;
    end
  end

  assign read_count        = read_count_q;
  assign read_gray         = read_gray_q;
  assign empty_flag        = empty_q;
  assign almost_empty_flag = almost_empty_q;
  assign read_level        = read_level_q;

endmodule : empty_gen

// File: tb/tb_empty_gen.sv
// Directed bench for empty_gen with SIZE=4 and ALMOST_EMPTY_LEVEL=2.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, so each sample shows the values registered on the edge just taken.
module tb_empty_gen;

  localparam int SIZE = 4;
  localparam int AEL  = 2;

  logic            read_clock;
  logic            reset_n;
  logic            valid_read;
  logic [SIZE-1:0] write_gray_pointer;
  logic [SIZE-1:0] read_count;
  logic [SIZE-1:0] read_gray;
  logic            empty_flag;
  logic            almost_empty_flag;
  logic [SIZE-1:0] read_level;

  int n_cmp = 0;
  int n_err = 0;

  empty_gen #(
    .SIZE               (SIZE),
    .ALMOST_EMPTY_LEVEL (AEL)
  ) dut (
    .read_clock         (read_clock),
    .reset_n            (reset_n),
    .valid_read         (valid_read),
    .write_gray_pointer (write_gray_pointer),
    .read_count         (read_count),
    .read_gray          (read_gray),
    .empty_flag         (empty_flag),
    .almost_empty_flag  (almost_empty_flag),
    .read_level         (read_level)
  );

  initial read_clock = 1'b0;
  always #5 read_clock = ~read_clock;

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: run reached time limit, expected to finish earlier");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Compare all five outputs against expected values.
  task automatic expect_outs(input string tag, input int cnt, input int gry,
                             input int emp, input int ae, input int lvl);
    check({tag, ".count"}, int'(read_count), cnt);
    check({tag, ".gray"},  int'(read_gray), gry);
    check({tag, ".empty"}, int'(empty_flag), emp);
    check({tag, ".aempty"}, int'(almost_empty_flag), ae);
    check({tag, ".level"}, int'(read_level), lvl);
  endtask

  task automatic tick();
    @(posedge read_clock);
    #1;
  endtask

  // Wait the three edges a write pointer change needs to reach the flags.
  task automatic land_write(input logic [SIZE-1:0] wg);
    write_gray_pointer = wg;
    tick();
    tick();
    tick();
  endtask

  initial begin
    // ---------------- reset with random inputs ----------------
    reset_n            = 1'b0;
    valid_read         = 1'b0;
    write_gray_pointer = '0;
    for (int i = 0; i < 4; i++) begin
      valid_read         = 1'($urandom);
      write_gray_pointer = SIZE'($urandom);
      tick();
    end
    expect_outs("reset", 0, 0, 1, 1, 0);

    write_gray_pointer = '0;
    valid_read         = 1'b1;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_reset_read.count", int'(read_count), 0);
    end
    check("post_reset_read.empty", int'(empty_flag), 1);

    // ---------------- fill 3 words then drain ----------------
    valid_read = 1'b0;
    write_gray_pointer = 4'b0010;   // gray(3)
    tick();
    tick();
    check("fill_e2.empty_still_set", int'(empty_flag), 1);
    tick();
    expect_outs("fill_e3", 0, 0, 0, 0, 3);

    valid_read = 1'b1;
    tick();
    expect_outs("drain1", 1, 4'b0001, 0, 1, 2);
    tick();
    expect_outs("drain2", 2, 4'b0011, 0, 1, 1);
    tick();
    expect_outs("drain3", 3, 4'b0010, 1, 1, 0);

    // ---------------- underflow: reads while empty ----------------
    for (int i = 0; i < 4; i++) begin
      tick();
      check("underflow.count", int'(read_count), 3);
      check("underflow.gray",  int'(read_gray), 4'b0010);
    end
    check("underflow.level", int'(read_level), 0);

    // ---------------- move pointers to 14, then wrap ----------------
    valid_read = 1'b0;
    land_write(4'b1001);            // gray(14)
    expect_outs("pre_wrap_fill", 3, 4'b0010, 0, 0, 11);
    valid_read = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    valid_read = 1'b0;
    expect_outs("pre_wrap_drain", 14, 4'b1001, 1, 1, 0);

    land_write(4'b0001);            // gray(1): write side wrapped
    expect_outs("wrap_ready", 14, 4'b1001, 0, 0, 3);
    valid_read = 1'b1;
    tick();
    expect_outs("wrap1", 15, 4'b1000, 0, 1, 2);
    tick();
    expect_outs("wrap2", 0, 4'b0000, 0, 1, 1);
    tick();
    expect_outs("wrap3", 1, 4'b0001, 1, 1, 0);
    valid_read = 1'b0;

    // ---------------- simultaneous read and write ----------------
    land_write(4'b0010);            // gray(3): level 2
    expect_outs("simul_pre", 1, 4'b0001, 0, 1, 2);
    write_gray_pointer = 4'b0110;   // gray(4)
    tick();                         // E1: sync stage 1
    tick();                         // E2: wgray_sync updated
    check("simul_e2.level", int'(read_level), 2);
    valid_read = 1'b1;
    tick();                         // E3: read and new pointer together
    valid_read = 1'b0;
    expect_outs("simul_e3", 2, 4'b0011, 0, 1, 2);

    // ---------------- full: write gray(8) vs read 0 ----------------
    reset_n = 1'b0;
    write_gray_pointer = '0;
    tick();
    reset_n = 1'b1;
    land_write(4'b1100);            // gray(8)
    expect_outs("full", 0, 0, 0, 0, 8);

    valid_read = 1'b1;
    tick();
    tick();
    tick();
    valid_read = 1'b0;
    expect_outs("level5", 3, 4'b0010, 0, 0, 5);

    // ---------------- mid-operation asynchronous reset ----------------
    #2;
    reset_n = 1'b0;
    #1;
    expect_outs("async_reset", 0, 0, 1, 1, 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_empty_gen
